// File: rtl/io_mmio_responder.sv
// io_mmio_responder: CPU-visible I/O register block for the 3-stage core.
// Holds the UART TX/RX byte FIFOs and the cycle/instruction counters, and
// returns registered load data one cycle after the load, like block RAM.
module io_mmio_responder #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_en,
  input  logic [31:0] addr,
  input  logic [3:0]  wea,
  input  logic        re,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        inst_retire,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [7:0] ADDR_STATUS  = 8'h00;
  localparam logic [7:0] ADDR_RX_DATA = 8'h04;
  localparam logic [7:0] ADDR_TX_DATA = 8'h08;
  localparam logic [7:0] ADDR_CYCLE   = 8'h10;
  localparam logic [7:0] ADDR_INSTR   = 8'h14;
  localparam logic [7:0] ADDR_CNT_CLR = 8'h18;

  // FIFO storage and bookkeeping
  logic [BYTE_W-1:0] tx_mem [FIFO_DEPTH];
  logic [BYTE_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  tx_rd_ptr, tx_wr_ptr, rx_rd_ptr, rx_wr_ptr;
  logic [CNT_W-1:0]  tx_count, rx_count;

  logic              tx_ovf, rx_und;
  logic [DATA_W-1:0] cycle_cnt, inst_cnt;

  logic [7:0]        sel;
  logic              load, store;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_wr_req, tx_push, tx_pop, tx_ovf_evt;
  logic              rx_rd_req, rx_push, rx_pop, rx_und_evt;
  logic              sticky_clr, cnt_clr;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] rd_data;

  // Bits of the bus this block never decodes
  logic unused_bits;
  assign unused_bits = ^{addr[31:8], din[31:8]};

  // Access decode and FIFO handshakes
  assign sel        = addr[7:0];
  assign load       = io_en & re;
  assign store      = io_en & (|wea);

  assign tx_full    = (tx_count == DEPTH_CNT);
  assign tx_empty   = (tx_count == '0);
  assign rx_full    = (rx_count == DEPTH_CNT);
  assign rx_empty   = (rx_count == '0);

  assign tx_pop     = ~tx_empty & uart_tx_ready;
  assign tx_wr_req  = store & (sel == ADDR_TX_DATA) & wea[0];
  // A pop on the same edge frees a slot, so a full FIFO still takes the byte
  assign tx_push    = tx_wr_req & (~tx_full | tx_pop);
  assign tx_ovf_evt = tx_wr_req & tx_full & ~tx_pop;

  assign rx_push    = uart_rx_valid & ~rx_full;
  assign rx_rd_req  = load & (sel == ADDR_RX_DATA);
  assign rx_pop     = rx_rd_req & ~rx_empty;
  assign rx_und_evt = rx_rd_req & rx_empty;

  assign sticky_clr = store & (sel == ADDR_STATUS);
  assign cnt_clr    = store & (sel == ADDR_CNT_CLR);

  assign status = {28'd0, rx_und, tx_ovf, ~rx_empty, ~tx_full};

  assign uart_tx_valid = ~tx_empty;
  assign uart_tx_data  = tx_mem[tx_rd_ptr];
  assign uart_rx_ready = ~rx_full;

  // Read mux over pre-edge state
  always_comb begin
    rd_data = '0;
    case (sel)
      ADDR_STATUS:  rd_data = status;
      ADDR_RX_DATA: rd_data = rx_empty ? '0 : {24'd0, rx_mem[rx_rd_ptr]};
      ADDR_CYCLE:   rd_data = cycle_cnt;
      ADDR_INSTR:   rd_data = inst_cnt;
      default:      rd_data = '0;
    endcase
  end

  // Registered load data, held between loads
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (load) begin
      dout <= rd_data;
    end
  end

  // TX FIFO: storage cleared on reset so the head byte reads 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem[i] <= '0;
      end
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr_ptr] <= din[BYTE_W-1:0];
        tx_wr_ptr         <= tx_wr_ptr + PTR_W'(1);
      end
      if (tx_pop) begin
        tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_W'(1);
        2'b01:   tx_count <= tx_count - CNT_W'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // RX FIFO storage, only ever read while non-empty
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr] <= uart_rx_data;
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) begin
        rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
      end
      if (rx_pop) begin
        rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_W'(1);
        2'b01:   rx_count <= rx_count - CNT_W'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Sticky error flags; a new event beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf <= 1'b0;
      rx_und <= 1'b0;
    end else begin
      tx_ovf <= tx_ovf_evt | (tx_ovf & ~sticky_clr);
      rx_und <= rx_und_evt | (rx_und & ~sticky_clr);
    end
  end

  // Performance counters; a clear store zeroes both on this edge
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + DATA_W'(1);
      inst_cnt  <= inst_cnt + DATA_W'(inst_retire);
    end
  end

endmodule

// File: tb/tb_io_mmio_responder.sv
// Bench for io_mmio_responder: directed register-map scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based model of the register map.
module tb_io_mmio_responder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_en;
  logic [31:0] addr;
  logic [3:0]  wea;
  logic        re;
  logic [31:0] din;
  logic [31:0] dout;
  logic        inst_retire;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;

  always #5 clk = ~clk;

  io_mmio_responder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .io_en(io_en), .addr(addr), .wea(wea), .re(re),
    .din(din), .dout(dout), .inst_retire(inst_retire),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready), .uart_tx_data(uart_tx_data),
    .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [7:0]  m_tx[$];
  logic [7:0]  m_rx[$];
  logic [31:0] m_cyc, m_ins, m_dout;
  logic        m_ovf, m_und;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one clock edge to the model using the current inputs
  task automatic model_edge();
    logic        ld, st, txpop, clr, ovf_e, und_e;
    logic [7:0]  a;
    logic [31:0] rdv;
    int          txn, rxn;
    if (rst) begin
      m_tx.delete();
      m_rx.delete();
      m_cyc = 0; m_ins = 0; m_dout = 0; m_ovf = 0; m_und = 0;
    end else begin
      ld  = io_en && re;
      st  = io_en && (wea != 4'd0);
      a   = addr[7:0];
      txn = m_tx.size();
      rxn = m_rx.size();
      rdv = 32'd0;
      case (a)
        8'h00: rdv = {28'd0, m_und, m_ovf, rxn != 0, txn != DEPTH};
        8'h04: rdv = (rxn != 0) ? 32'(m_rx[0]) : 32'd0;
        8'h10: rdv = m_cyc;
        8'h14: rdv = m_ins;
        default: rdv = 32'd0;
      endcase
      if (ld) m_dout = rdv;
      ovf_e = 1'b0;
      und_e = 1'b0;
      txpop = (txn > 0) && uart_tx_ready;
      if (txpop) void'(m_tx.pop_front());
      if (st && a == 8'h08 && wea[0]) begin
        if (txn < DEPTH || txpop) m_tx.push_back(din[7:0]);
        else ovf_e = 1'b1;
      end
      if (ld && a == 8'h04) begin
        if (rxn > 0) void'(m_rx.pop_front());
        else und_e = 1'b1;
      end
      if (uart_rx_valid && rxn < DEPTH) m_rx.push_back(uart_rx_data);
      clr   = st && (a == 8'h00);
      m_ovf = ovf_e || (m_ovf && !clr);
      m_und = und_e || (m_und && !clr);
      if (st && a == 8'h18) begin
        m_cyc = 0;
        m_ins = 0;
      end else begin
        m_cyc = m_cyc + 32'd1;
        m_ins = m_ins + 32'(inst_retire);
      end
    end
  endtask

  // One cycle: edge, model update, then compare all outputs 1ns later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("dout", dout, m_dout);
    chk("tx_valid", 32'(uart_tx_valid), 32'(m_tx.size() != 0));
    chk("rx_ready", 32'(uart_rx_ready), 32'(m_rx.size() != DEPTH));
    if (m_tx.size() != 0) chk("tx_data", 32'(uart_tx_data), 32'(m_tx[0]));
  endtask

  task automatic cpu_load(input logic [7:0] a);
    io_en = 1'b1; re = 1'b1; wea = 4'd0; addr = {24'd0, a};
    step();
    io_en = 1'b0; re = 1'b0;
  endtask

  task automatic cpu_store(input logic [7:0] a, input logic [31:0] d);
    io_en = 1'b1; re = 1'b0; wea = 4'hF; addr = {24'd0, a}; din = d;
    step();
    io_en = 1'b0; wea = 4'd0;
  endtask

  initial begin
    logic [31:0] tmp;
    logic [7:0]  a8;
    int          phase;
    rst = 1'b1; io_en = 1'b0; addr = '0; wea = '0; re = 1'b0; din = '0;
    inst_retire = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_dout", dout, 32'h0);
    chk("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
    chk("rst_rx_ready", 32'(uart_rx_ready), 32'h1);
    chk("rst_tx_data", 32'(uart_tx_data), 32'h0);

    cpu_load(8'h00);
    chk("status_after_reset", dout, 32'h1);

    // Single TX byte, held until the transmitter is ready
    cpu_store(8'h08, 32'h41);
    chk("tx_one_valid", 32'(uart_tx_valid), 32'h1);
    chk("tx_one_data", 32'(uart_tx_data), 32'h41);
    uart_tx_ready = 1'b1;
    step();
    uart_tx_ready = 1'b0;
    chk("tx_one_drained", 32'(uart_tx_valid), 32'h0);

    // Overfill TX, then clear the sticky bit
    for (int i = 0; i < 9; i++) cpu_store(8'h08, 32'(8'hA0 + i));
    cpu_load(8'h00);
    chk("status_tx_ovf", dout, 32'h4);
    cpu_store(8'h00, 32'h0);
    cpu_load(8'h00);
    chk("status_ovf_cleared", dout, 32'h0);
    chk("tx_head_first", 32'(uart_tx_data), 32'hA0);
    uart_tx_ready = 1'b1;
    repeat (DEPTH) step();
    uart_tx_ready = 1'b0;
    chk("tx_drained", 32'(uart_tx_valid), 32'h0);

    // Two RX bytes, then an underflow read
    uart_rx_valid = 1'b1; uart_rx_data = 8'h10;
    step();
    uart_rx_data = 8'h20;
    step();
    uart_rx_valid = 1'b0;
    cpu_load(8'h00);
    chk("status_rx_nonempty", dout, 32'h3);
    cpu_load(8'h04);
    chk("rx_first", dout, 32'h10);
    cpu_load(8'h04);
    chk("rx_second", dout, 32'h20);
    cpu_load(8'h04);
    chk("rx_underflow_data", dout, 32'h0);
    cpu_load(8'h00);
    chk("status_rx_und", dout, 32'h9);
    cpu_store(8'h00, 32'h0);

    // Fill RX, then one CPU pop reopens it
    uart_rx_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      uart_rx_data = 8'(i + 1);
      step();
    end
    uart_rx_valid = 1'b0;
    chk("rx_full_ready", 32'(uart_rx_ready), 32'h0);
    cpu_load(8'h04);
    chk("rx_full_pop_data", dout, 32'h1);
    chk("rx_ready_after_pop", 32'(uart_rx_ready), 32'h1);
    repeat (DEPTH - 1) cpu_load(8'h04);
    chk("rx_last_data", dout, 32'(DEPTH));

    // Counters: 100 cycles after reset with 37 retires
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      inst_retire = (i < 37);
      step();
    end
    inst_retire = 1'b0;
    cpu_load(8'h10);
    chk("cycle_100", dout, 32'd100);
    cpu_load(8'h14);
    chk("instr_37", dout, 32'd37);
    inst_retire = 1'b1;
    cpu_store(8'h18, 32'h0);
    inst_retire = 1'b0;
    cpu_load(8'h10);
    chk("cycle_cleared", dout, 32'd0);
    cpu_load(8'h14);
    chk("instr_cleared", dout, 32'd0);

    // Randomized traffic, alternating drain-heavy and fill-heavy phases
    for (int i = 0; i < 6000; i++) begin
      phase = (i / 500) % 2;
      rst   = ($urandom_range(0, 299) == 0);
      io_en = ($urandom_range(0, 3) != 0);
      re    = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 8))
        0: a8 = 8'h00;
        1: a8 = 8'h04;
        2: a8 = 8'h08;
        3: a8 = 8'h10;
        4: a8 = 8'h14;
        5: a8 = 8'h18;
        6: a8 = 8'h0C;
        7: a8 = 8'h08;
        default: a8 = 8'($urandom());
      endcase
      tmp  = $urandom();
      addr = {tmp[31:8], a8};
      wea  = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'd0;
      din  = $urandom();
      inst_retire   = ($urandom_range(0, 1) == 1);
      uart_rx_data  = 8'($urandom());
      uart_rx_valid = (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      uart_tx_ready = (phase == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_mmio_responder.md
# io_mmio_responder

Memory-mapped I/O responder for the 3-stage RISC-V core. It services every CPU load or store that the address decoder steers to the I/O region (data address upper nibble 4'b1000). It owns the UART TX/RX byte FIFOs and the cycle and instruction performance counters, and returns registered read data the cycle after a load, matching the block-RAM read latency of the data and BIOS memories.

## Interface
Parameters:
- FIFO_DEPTH, 8: entries per UART FIFO; power of two, ≥2.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- io_en  in  1  I/O region selected for this access (decoder mem_or_IO)
- addr  in  32  data address; only addr[7:0] decoded
- wea  in  4  byte write enables; store when io_en & |wea
- re  in  1  load in progress; load when io_en & re
- din  in  32  store data
- dout  out  32  registered load data
- inst_retire  in  1  one-cycle pulse per retired instruction
- uart_rx_data  in  8  byte from UART receiver
- uart_rx_valid  in  1  receiver byte valid
- uart_rx_ready  out  1  RX FIFO can accept
- uart_tx_data  out  8  byte to UART transmitter
- uart_tx_valid  out  1  TX FIFO non-empty
- uart_tx_ready  in  1  transmitter can accept

## Operation
Register map (addr[7:0]):
- 0x00 R status: bit0 = TX not full, bit1 = RX not empty, bit2 = sticky TX overflow, bit3 = sticky RX-read-underflow, others 0. Any store to 0x00 clears bits 2–3.
- 0x04 R RX data: {24'b0, RX head}; load pops. If RX empty: returns 0, no pop, sets bit3.
- 0x08 W TX data: store with wea[0]=1 pushes din[7:0]. If full and no same-cycle pop: byte dropped, bit2 set. wea[0]=0 is ignored.
- 0x10 R cycle counter, 32-bit, increments every non-reset cycle, wraps 0xFFFFFFFF→0.
- 0x14 R instruction counter, 32-bit, +1 per inst_retire, wraps.
- 0x18 W any store zeroes both counters.
- Unmapped loads return 0. Unmapped stores are ignored. Loads and stores with io_en=0 have no effect.
- Each FIFO is a circular buffer with read and write pointers and an occupancy count of $clog2(FIFO_DEPTH)+1 bits. Pointers wrap at FIFO_DEPTH.
- TX FIFO: uart_tx_valid = count≠0; uart_tx_data = head entry (no fall-through). Pop on uart_tx_valid & uart_tx_ready. Push and pop in the same cycle while full: push accepted, count unchanged. Push into an empty FIFO appears on uart_tx_valid the next cycle.
- RX FIFO: uart_rx_ready = count≠FIFO_DEPTH. Push on uart_rx_valid & uart_rx_ready. A CPU pop in the same cycle as a push is legal: count unchanged. CPU pop while full plus UART push is impossible because ready=0.

## Timing
- Reset values: dout=0, both counters 0, FIFOs empty, sticky bits 0, uart_tx_valid=0, uart_rx_ready=1, uart_tx_data=0.
- Load latency is 1. dout captures the selected register at the edge ending the load cycle. dout holds its value on cycles with no load.
- All read values are pre-edge state. A status read in the same cycle as a push does not see that push. A counter read returns the value before that cycle's increment.
- A counter-clear store takes effect at the edge: the next cycle reads 0, and counting resumes from there. A clear coinciding with inst_retire gives instruction counter 0.
- A sticky-clear store coinciding with a new overflow or underflow event leaves the bit set (the set wins).
- rst asserted mid-transfer discards FIFO contents on that edge. A load in the reset cycle returns 0.

## Test plan
- Reset, then load 0x00 → dout=0x00000001 next cycle; uart_tx_valid=0; uart_rx_ready=1.
- Store 0x41 to 0x08 with uart_tx_ready=0 → uart_tx_valid=1, uart_tx_data=0x41. Raise ready for one cycle → valid=0.
- With uart_tx_ready=0, store 9 bytes (FIFO_DEPTH=8) → 9th dropped, status=0x00000004. Then store to 0x00 → status=0x00000000.
- Drive RX bytes 0x10, 0x20 → status bit1=1. Loads at 0x04 return 0x10, then 0x20. A third load returns 0 and sets status bit3.
- Fill RX to 8 entries → uart_rx_ready=0. One CPU pop → ready=1 next cycle.
- Run 100 cycles with 37 inst_retire pulses after reset → 0x10 reads 100 ±1 per the read-cycle rule, 0x14 reads 37. Store to 0x18 → both read 0 on the following load.
